mips_prog_loader: RTL and testbench

// - Synthesizable program-load / run / dump sequencer in front of mips_np; replaces the bench-driven instruction-load sequence.
// - Streams a program into instruction memory while holding the core in reset, releases the core for a fixed cycle budget, then streams a data-memory window out.
// - Width and depth are parametrised for the next core generation.

---
 rtl/mips_prog_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_mips_prog_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mips_prog_loader
// Description : Program-load / run / dump sequencer placed in front of mips_np.
//               Streams a program into instruction memory with the core held in
//               reset. Releases the core for a fixed number of cycles. Then
//               streams a window of data memory out over a valid/ready port.
//               Optional build macro LOADER_VERIFY_EN adds a checksum
//               read-back pass (VERIFY state) between LOAD and RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_prog_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int CYC_W  = 16
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              start_in,
    input  logic [ADDR_W:0]   load_count_in,
    input  logic [CYC_W-1:0]  run_cycles_in,
    input  logic [ADDR_W-1:0] dump_base_in,
    input  logic [ADDR_W:0]   dump_count_in,
    input  logic              word_valid_in,
    input  logic [DATA_W-1:0] word_in,
    output logic              word_ready_out,
    output logic              cpu_reset_out,
    output logic              instrWrite_out,
    output logic [ADDR_W-1:0] instr_address_out,
    output logic [DATA_W-1:0] instr_out,
    input  logic [DATA_W-1:0] read_instr_in,
    output logic [ADDR_W-1:0] read_data_address_out,
    input  logic [DATA_W-1:0] read_data_in,
    output logic              dump_valid_out,
    output logic [DATA_W-1:0] dump_data_out,
    input  logic              dump_ready_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_VERIFY = 3'd2,
        S_RUN    = 3'd3,
        S_DUMP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Instruction memory depth, expressed in the count width.
    localparam logic [ADDR_W:0]  c_depth = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  c_one_a = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] c_one_c = {{(CYC_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_load_count;
    logic [CYC_W-1:0]  r_run_cycles;
    logic [ADDR_W-1:0] r_dump_base;
    logic [ADDR_W:0]   r_dump_count;
    logic [ADDR_W:0]   r_load_idx;
    logic [CYC_W-1:0]  r_run_cnt;
    logic [ADDR_W:0]   r_dump_idx;
    logic              r_error;

    logic              w_start;
    logic              w_lc_over;
    logic [ADDR_W:0]   w_lc_clamp;
    logic              w_load_hs;
    logic              w_load_last;
    logic              w_run_last;
    logic              w_dump_hs;
    logic              w_dump_last;
    logic              w_ver_bad;

    // Chooses the first state after loading (and verifying): RUN, or skip
    // straight to DUMP/DONE when there is nothing to run or dump.
    function automatic state_t f_to_run(input logic [CYC_W-1:0] rc,
                                        input logic [ADDR_W:0]  dc);
        state_t s;
        if (rc != '0)
            s = S_RUN;
        else if (dc != '0)
            s = S_DUMP;
        else
            s = S_DONE;
        return s;
    endfunction

    assign w_start     = start_in & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_lc_over   = (load_count_in > c_depth);
    assign w_lc_clamp  = w_lc_over ? c_depth : load_count_in;
    assign w_load_hs   = (r_state == S_LOAD) & word_valid_in;
    assign w_load_last = w_load_hs & (r_load_idx == (r_load_count - c_one_a));
    assign w_run_last  = (r_state == S_RUN) & (r_run_cnt == (r_run_cycles - c_one_c));
    assign w_dump_hs   = (r_state == S_DUMP) & dump_ready_in;
    assign w_dump_last = w_dump_hs & (r_dump_idx == (r_dump_count - c_one_a));
    assign error_out   = r_error;

`ifdef LOADER_VERIFY_EN
    logic [DATA_W-1:0] r_checksum;
    logic [DATA_W-1:0] r_ver_acc;
    logic [ADDR_W:0]   r_ver_idx;
    logic              w_ver_last;

    assign w_ver_last = (r_state == S_VERIFY) & (r_ver_idx == (r_load_count - c_one_a));
    assign w_ver_bad  = w_ver_last & ((r_ver_acc ^ read_instr_in) != r_checksum);

    // Checksum of accepted words, and the read-back accumulator used in VERIFY.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_checksum <= '0;
            r_ver_acc  <= '0;
            r_ver_idx  <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
            r_ver_acc  <= '0;
            r_ver_idx  <= '0;
        end else begin
            if (w_load_hs)
                r_checksum <= r_checksum ^ word_in;
            if (r_state == S_VERIFY) begin
                r_ver_acc <= r_ver_acc ^ read_instr_in;
                r_ver_idx <= r_ver_idx + c_one_a;
            end
        end
    end
`else
    logic w_unused_read;
    assign w_unused_read = ^read_instr_in;
    assign w_ver_bad     = 1'b0;
`endif

    // State register, latched configuration, progress counters and sticky error.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state      <= S_IDLE;
            r_load_count <= '0;
            r_run_cycles <= '0;
            r_dump_base  <= '0;
            r_dump_count <= '0;
            r_load_idx   <= '0;
            r_run_cnt    <= '0;
            r_dump_idx   <= '0;
            r_error      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_load_count <= w_lc_clamp;
                r_run_cycles <= run_cycles_in;
                r_dump_base  <= dump_base_in;
                r_dump_count <= dump_count_in;
                r_load_idx   <= '0;
                r_run_cnt    <= '0;
                r_dump_idx   <= '0;
                r_error      <= w_lc_over;
            end else begin
                if (w_load_hs)
                    r_load_idx <= r_load_idx + c_one_a;
                if (r_state == S_RUN)
                    r_run_cnt <= r_run_cnt + c_one_c;
                if (w_dump_hs)
                    r_dump_idx <= r_dump_idx + c_one_a;
                if (w_ver_bad)
                    r_error <= 1'b1;
            end
        end
    end

    // Next-state selection and state-decoded outputs.
    always_comb begin
        w_next                = r_state;
        word_ready_out        = 1'b0;
        instrWrite_out        = 1'b0;
        instr_address_out     = '0;
        instr_out             = '0;
        read_data_address_out = '0;
        dump_valid_out        = 1'b0;
        dump_data_out         = '0;
        cpu_reset_out         = 1'b1;
        busy_out              = 1'b1;
        done_out              = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                busy_out = 1'b0;
                done_out = (r_state == S_DONE);
                if (start_in)
                    w_next = (w_lc_clamp == '0) ? f_to_run(run_cycles_in, dump_count_in)
                                                : S_LOAD;
            end
            S_LOAD: begin
                word_ready_out    = 1'b1;
                instrWrite_out    = word_valid_in;
                instr_address_out = r_load_idx[ADDR_W-1:0];
                instr_out         = word_in;
`ifdef LOADER_VERIFY_EN
                if (w_load_last)
                    w_next = S_VERIFY;
`else
                if (w_load_last)
                    w_next = f_to_run(r_run_cycles, r_dump_count);
`endif
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY: begin
                instr_address_out = r_ver_idx[ADDR_W-1:0];
                if (w_ver_last)
                    w_next = w_ver_bad ? S_DONE : f_to_run(r_run_cycles, r_dump_count);
            end
`endif
            S_RUN: begin
                cpu_reset_out = 1'b0;
                if (w_run_last)
                    w_next = (r_dump_count != '0) ? S_DUMP : S_DONE;
            end
            S_DUMP: begin
                dump_valid_out        = 1'b1;
                read_data_address_out = r_dump_base + r_dump_idx[ADDR_W-1:0];
                dump_data_out         = read_data_in;
                if (w_dump_last)
                    w_next = S_DONE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mips_prog_loader
// Description : Directed self-checking bench for mips_prog_loader. Models the
//               instruction and data memories; expected load writes and dump
//               addresses are queued as stimulus is issued and popped as the
//               loader produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_prog_loader;

    logic        clk;
    logic        reset_in;
    logic        start_in;
    logic [8:0]  load_count_in;
    logic [15:0] run_cycles_in;
    logic [7:0]  dump_base_in;
    logic [8:0]  dump_count_in;
    logic        word_valid_in;
    logic [31:0] word_in;
    logic        word_ready_out;
    logic        cpu_reset_out;
    logic        instrWrite_out;
    logic [7:0]  instr_address_out;
    logic [31:0] instr_out;
    logic [31:0] read_instr_in;
    logic [7:0]  read_data_address_out;
    logic [31:0] read_data_in;
    logic        dump_valid_out;
    logic [31:0] dump_data_out;
    logic        dump_ready_in;
    logic        busy_out;
    logic        done_out;
    logic        error_out;

    int          checks;
    int          errors;
    logic        corrupt;
    logic [31:0] imem [256];
    logic [31:0] words [3];
    logic [39:0] lq [$];
    logic [7:0]  dq [$];
    logic [39:0] le;
    int          sent;
    int          low;
    int          pulses;
    int          lows;

    mips_prog_loader #(.DATA_W(32), .ADDR_W(8), .CYC_W(16)) dut (
        .clock_in              (clk),
        .reset_in              (reset_in),
        .start_in              (start_in),
        .load_count_in         (load_count_in),
        .run_cycles_in         (run_cycles_in),
        .dump_base_in          (dump_base_in),
        .dump_count_in         (dump_count_in),
        .word_valid_in         (word_valid_in),
        .word_in               (word_in),
        .word_ready_out        (word_ready_out),
        .cpu_reset_out         (cpu_reset_out),
        .instrWrite_out        (instrWrite_out),
        .instr_address_out     (instr_address_out),
        .instr_out             (instr_out),
        .read_instr_in         (read_instr_in),
        .read_data_address_out (read_data_address_out),
        .read_data_in          (read_data_in),
        .dump_valid_out        (dump_valid_out),
        .dump_data_out         (dump_data_out),
        .dump_ready_in         (dump_ready_in),
        .busy_out              (busy_out),
        .done_out              (done_out),
        .error_out             (error_out)
    );

    function automatic logic [31:0] dmem(input logic [7:0] a);
        return 32'hDA7A_0000 | {24'h0, a};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: synchronous write, asynchronous read with an
    // optional single-bit corruption at address 1.
    always @(posedge clk) begin
        if (instrWrite_out)
            imem[instr_address_out] <= instr_out;
    end
    assign read_instr_in = imem[instr_address_out] ^
                           ((corrupt && instr_address_out == 8'd1) ? 32'h1 : 32'h0);
    assign read_data_in  = dmem(read_data_address_out);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cpu_reset"}, cpu_reset_out, 1);
        check({tag, "_ready"},     word_ready_out, 0);
        check({tag, "_we"},        instrWrite_out, 0);
        check({tag, "_dvalid"},    dump_valid_out, 0);
        check({tag, "_busy"},      busy_out, 0);
        check({tag, "_done"},      done_out, 0);
        check({tag, "_error"},     error_out, 0);
        check({tag, "_iaddr"},     instr_address_out, 0);
        check({tag, "_daddr"},     read_data_address_out, 0);
    endtask

    initial begin
        checks = 0; errors = 0; corrupt = 1'b0;
        words[0] = 32'h2008_0005; words[1] = 32'h2009_0003; words[2] = 32'h0109_5020;
        reset_in = 1'b1; start_in = 1'b0; load_count_in = '0; run_cycles_in = '0;
        dump_base_in = '0; dump_count_in = '0; word_valid_in = 1'b0; word_in = '0;
        dump_ready_in = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_reset("rst");
        reset_in = 1'b0;

        // ---- Load three words with a valid gap, run 10, dump FE..01 ----
        @(negedge clk);
        start_in = 1'b1; load_count_in = 9'd3; run_cycles_in = 16'd10;
        dump_base_in = 8'hFE; dump_count_in = 9'd4;
        dq.push_back(8'hFE); dq.push_back(8'hFF); dq.push_back(8'h00); dq.push_back(8'h01);
        #1 check("idle_busy", busy_out, 0);
        sent = 0;
        for (int c = 0; c < 20 && sent < 3; c++) begin
            @(negedge clk);
            start_in      = 1'b0;
            word_valid_in = (c != 1);
            word_in       = words[sent];
            if (word_valid_in)
                lq.push_back({sent[7:0], words[sent]});
            #1;
            check("load_ready", word_ready_out, 1);
            check("load_we", instrWrite_out, word_valid_in);
            if (instrWrite_out && lq.size() > 0) begin
                le = lq.pop_front();
                check("load_addr", instr_address_out, le[39:32]);
                check("load_data", instr_out, le[31:0]);
            end
            if (word_valid_in)
                sent++;
        end
        @(negedge clk);
        word_valid_in = 1'b0;
        #1;
        check("load_exit_ready", word_ready_out, 0);
        check("load_exit_busy", busy_out, 1);
        check("load_queue_empty", lq.size(), 0);

        // Count released cycles; pulse start mid-run, which must be ignored.
        low = 0;
        for (int c = 0; c < 60; c++) begin
            if (!cpu_reset_out)
                low++;
            else if (low > 0)
                break;
            start_in = (low == 3);
            if (start_in) begin
                load_count_in = 9'd5;
                dump_base_in  = 8'h40;
            end
            @(negedge clk); #1;
        end
        start_in = 1'b0;
        check("run_len", low, 10);

        // Dump with dump_ready toggling; the head of the queue must hold while stalled.
        for (int c = 0; c < 40 && dq.size() > 0; c++) begin
            dump_ready_in = (c % 2 == 1);
            #1;
            check("dump_valid", dump_valid_out, 1);
            check("dump_addr", read_data_address_out, dq[0]);
            check("dump_data", dump_data_out, dmem(dq[0]));
            check("dump_cpu_reset", cpu_reset_out, 1);
            if (dump_ready_in)
                void'(dq.pop_front());
            @(negedge clk); #1;
        end
        dump_ready_in = 1'b0;
        check("dump_remaining", dq.size(), 0);
        check("t1_done", done_out, 1);
        check("t1_busy", busy_out, 0);
        check("t1_cpu_reset", cpu_reset_out, 1);
        check("t1_dvalid", dump_valid_out, 0);
        check("t1_error", error_out, 0);

        // ---- Zero configuration: IDLE straight to DONE ----
        reset_in = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_reset("rst2");
        reset_in = 1'b0;
        @(negedge clk);
        start_in = 1'b1; load_count_in = '0; run_cycles_in = '0; dump_count_in = '0;
        @(negedge clk);
        start_in = 1'b0;
        #1;
        check("zero_done", done_out, 1);
        check("zero_busy", busy_out, 0);
        lows = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (!cpu_reset_out)
                lows++;
        end
        check("zero_never_released", lows, 0);
        check("zero_done_held", done_out, 1);

        // ---- Over-size load count clamps to full depth and flags error ----
        @(negedge clk);
        start_in = 1'b1; load_count_in = 9'd300; run_cycles_in = 16'd1;
        dump_base_in = 8'h00; dump_count_in = 9'd1;
        @(negedge clk);
        start_in = 1'b0; word_valid_in = 1'b1; word_in = '0; pulses = 0;
        #1 check("clamp_err", error_out, 1);
        for (int c = 0; c < 300; c++) begin
            if (!word_ready_out)
                break;
            if (instrWrite_out) begin
                check("clamp_addr", instr_address_out, pulses[7:0]);
                pulses++;
            end
            @(negedge clk);
            word_in = pulses;
            #1;
        end
        word_valid_in = 1'b0;
        check("clamp_count", pulses, 256);
        dump_ready_in = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (done_out)
                break;
            @(negedge clk); #1;
        end
        dump_ready_in = 1'b0;
        check("clamp_done", done_out, 1);
        check("clamp_err_sticky", error_out, 1);

        // ---- Restart clears error; reset asserted mid-DUMP ----
        @(negedge clk);
        start_in = 1'b1; load_count_in = 9'd1; run_cycles_in = 16'd2;
        dump_base_in = 8'h10; dump_count_in = 9'd3;
        @(negedge clk);
        start_in = 1'b0; word_valid_in = 1'b1; word_in = 32'h1234_5678;
        #1 check("restart_err_clear", error_out, 0);
        check("restart_done_clear", done_out, 0);
        for (int c = 0; c < 20; c++) begin
            if (dump_valid_out)
                break;
            @(negedge clk); #1;
        end
        word_valid_in = 1'b0;
        check("mid_dump_valid", dump_valid_out, 1);
        check("mid_dump_addr", read_data_address_out, 8'h10);
        reset_in = 1'b1;
        @(negedge clk); #1;
        check("rst_dump_busy", busy_out, 0);
        check("rst_dump_dvalid", dump_valid_out, 0);
        check("rst_dump_cpu_reset", cpu_reset_out, 1);
        check("rst_dump_done", done_out, 0);
        reset_in = 1'b0;

`ifdef LOADER_VERIFY_EN
        // ---- Corrupted read-back at address 1 aborts to DONE with error ----
        corrupt = 1'b1;
        @(negedge clk);
        start_in = 1'b1; load_count_in = 9'd3; run_cycles_in = 16'd10;
        dump_base_in = 8'h00; dump_count_in = 9'd2;
        @(negedge clk);
        start_in = 1'b0; word_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            word_in = words[i];
            #1;
            check("ver_load_we", instrWrite_out, 1);
            @(negedge clk);
        end
        word_valid_in = 1'b0;
        lows = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!cpu_reset_out)
                lows++;
            if (done_out)
                break;
            @(negedge clk);
        end
        check("ver_never_released", lows, 0);
        check("ver_done", done_out, 1);
        check("ver_error", error_out, 1);
        corrupt = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
